// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Register 0 is hardwired to zero, so writes to it are always harmless.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int NUM_REGS       = 32;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_MEM
    } grant_e;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] pos);
        logic [NUM_REGS-1:0] mask;
        mask      = '0;
        mask[pos] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Circular writeback buffer holding (pos, value) pairs for one source.
// Per-slot valid/pos are exported so the top level can build the hazard mask.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 push,
    input  logic [REG_ADDR_W-1:0]                push_pos,
    input  logic [DATA_W-1:0]                    push_value,
    input  logic                                 pop,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic                                 empty,
    output logic [REG_ADDR_W-1:0]                head_pos,
    output logic [DATA_W-1:0]                    head_value,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_pos
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]                  rd_ptr;
    logic [PTR_W-1:0]                  wr_ptr;
    logic [DEPTH-1:0][DATA_W-1:0]      value_q;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  pos_q;
    logic [DEPTH-1:0]                  valid_q;
    logic                              full;
    logic                              do_push;
    logic                              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Push and pop never touch the same slot: that needs full or empty, which the guards exclude.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            value_q <= '0;
            pos_q   <= '0;
        end else begin
            if (do_push) begin
                value_q[wr_ptr] <= push_value;
                pos_q[wr_ptr]   <= push_pos;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_pos    = pos_q[rd_ptr];
    assign head_value  = value_q[rd_ptr];
    assign entry_valid = valid_q;
    assign entry_pos   = pos_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths.
// Loads win by default; an ALU entry that keeps losing is eventually forced through.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3,
    parameter int DATA_W       = DATA_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_pos,
    input  logic [DATA_W-1:0]     alu_value,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_pos,
    input  logic [DATA_W-1:0]     mem_value,
    output logic [REG_ADDR_W-1:0] wb_pos,
    output logic [DATA_W-1:0]     wb_value,
    output logic [NUM_REGS-1:0]   pending_mask
);

    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]                  alu_count, mem_count;
    logic                              alu_empty, mem_empty;
    logic                              alu_push, mem_push;
    logic                              alu_pop, mem_pop;
    logic [REG_ADDR_W-1:0]             alu_head_pos, mem_head_pos;
    logic [DATA_W-1:0]                 alu_head_value, mem_head_value;
    logic [DEPTH-1:0]                  alu_entry_valid, mem_entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  alu_entry_pos, mem_entry_pos;
    logic [STARVE_W-1:0]               starve_cnt;
    grant_e                            grant;

    // Readiness uses the pre-edge count only, so a full queue stays not-ready even while draining.
    assign alu_ready = reset_n && (alu_count < DEPTH_CNT);
    assign mem_ready = reset_n && (mem_count < DEPTH_CNT);
    assign alu_push  = alu_valid && alu_ready && (alu_pos != REG_ZERO);
    assign mem_push  = mem_valid && mem_ready && (mem_pos != REG_ZERO);
    assign alu_pop   = (grant == GRANT_ALU);
    assign mem_pop   = (grant == GRANT_MEM);

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_alu_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (alu_push),
        .push_pos    (alu_pos),
        .push_value  (alu_value),
        .pop         (alu_pop),
        .count       (alu_count),
        .empty       (alu_empty),
        .head_pos    (alu_head_pos),
        .head_value  (alu_head_value),
        .entry_valid (alu_entry_valid),
        .entry_pos   (alu_entry_pos)
    );

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (mem_push),
        .push_pos    (mem_pos),
        .push_value  (mem_value),
        .pop         (mem_pop),
        .count       (mem_count),
        .empty       (mem_empty),
        .head_pos    (mem_head_pos),
        .head_value  (mem_head_value),
        .entry_valid (mem_entry_valid),
        .entry_pos   (mem_entry_pos)
    );

    always_comb begin
        grant = GRANT_NONE;
        if (!alu_empty && !mem_empty) begin
            grant = (starve_cnt == STARVE_MAX) ? GRANT_ALU : GRANT_MEM;
        end else if (!alu_empty) begin
            grant = GRANT_ALU;
        end else if (!mem_empty) begin
            grant = GRANT_MEM;
        end
    end

    // Idle cycles write zero to register 0, which the register file ignores.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_pos     <= REG_ZERO;
            wb_value   <= '0;
            starve_cnt <= '0;
        end else begin
            case (grant)
                GRANT_ALU: begin
                    wb_pos   <= alu_head_pos;
                    wb_value <= alu_head_value;
                end
                GRANT_MEM: begin
                    wb_pos   <= mem_head_pos;
                    wb_value <= mem_head_value;
                end
                default: begin
                    wb_pos   <= REG_ZERO;
                    wb_value <= '0;
                end
            endcase
            if (alu_empty || grant == GRANT_ALU) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // The wb stage is excluded: the register file forwards its in-flight write.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_entry_valid[i]) pending_mask = pending_mask | onehot_reg(alu_entry_pos[i]);
            if (mem_entry_valid[i]) pending_mask = pending_mask | onehot_reg(mem_entry_pos[i]);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with DEPTH=2, STARVE_LIMIT=3.
// Outputs are sampled at the falling edge; inputs change there too.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_pos;
    logic [31:0] alu_value;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_pos;
    logic [31:0] mem_value;
    logic [4:0]  wb_pos;
    logic [31:0] wb_value;
    logic [31:0] pending_mask;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] rf [32];
    logic [4:0]  mpos;
    logic [4:0]  alu_seen [$];

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(3), .DATA_W(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_pos      (alu_pos),
        .alu_value    (alu_value),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_pos      (mem_pos),
        .mem_value    (mem_value),
        .wb_pos       (wb_pos),
        .wb_value     (wb_value),
        .pending_mask (pending_mask)
    );

    always #5 clock = ~clock;

    // Register file model: commits the wb stage on each rising edge, register 0 ignored.
    always @(posedge clock) begin
        if (wb_pos != 5'd0) rf[wb_pos] <= wb_value;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cycle(output logic alu_acc);
        logic mem_acc;
        alu_acc = alu_valid && alu_ready;
        mem_acc = mem_valid && mem_ready;
        tick();
        if (mem_acc) begin
            mpos      = (mpos == 5'd15) ? 5'd1 : mpos + 5'd1;
            mem_pos   = mpos;
            mem_value = 32'h1000_0000 | 32'(mpos);
        end
        if (wb_pos >= 5'd16) alu_seen.push_back(wb_pos);
    endtask

    task automatic drain();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        alu_valid = 1'b0; alu_pos = '0; alu_value = '0;
        mem_valid = 1'b0; mem_pos = '0; mem_value = '0;
        repeat (2) tick();
        tests_run++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got alu=%b mem=%b expected 0 0", alu_ready, mem_ready);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (wb_pos !== 5'd0 || wb_value !== 32'd0 || alu_ready !== 1'b1 ||
                mem_ready !== 1'b1 || pending_mask !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL idle_%0d: got pos=%0d val=%h ar=%b mr=%b mask=%h expected 0 0 1 1 0",
                         i, wb_pos, wb_value, alu_ready, mem_ready, pending_mask);
            end
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_pos = 5'd5; alu_value = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        tests_run++;
        if (pending_mask !== 32'h0000_0020 || wb_pos !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_pending: got mask=%h pos=%0d expected 00000020 0", pending_mask, wb_pos);
        end
        tick();
        tests_run++;
        if (wb_pos !== 5'd5 || wb_value !== 32'hDEAD_BEEF || pending_mask !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_wb: got pos=%0d val=%h mask=%h expected 5 deadbeef 0",
                     wb_pos, wb_value, pending_mask);
        end
        tick();
        tests_run++;
        if (rf[5] !== 32'hDEAD_BEEF || wb_pos !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_commit: got rf5=%h pos=%0d expected deadbeef 0", rf[5], wb_pos);
        end
    endtask

    task automatic test_reg0_drop();
        logic acc;
        alu_valid = 1'b1; alu_pos = 5'd0; alu_value = 32'h0000_1234;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reg0_ready: got %b expected 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        tests_run++;
        if (pending_mask !== 32'd0 || wb_pos !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reg0_queue: got mask=%h pos=%0d expected 0 0", pending_mask, wb_pos);
        end
        tick();
        tests_run++;
        if (wb_pos !== 5'd0 || wb_value !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reg0_wb: got pos=%0d val=%h expected 0 0", wb_pos, wb_value);
        end
        // With loads hogging the port, dropped entries must not fill the ALU queue.
        mpos = 5'd1; mem_pos = 5'd1; mem_value = 32'h1000_0001; mem_valid = 1'b1;
        alu_valid = 1'b1; alu_pos = 5'd0; alu_value = 32'h0000_1234;
        cycle(acc);
        cycle(acc);
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reg0_count: got alu_ready=%b expected 1", alu_ready);
        end
        alu_pos = 5'd9; alu_value = 32'h0000_0009;
        cycle(acc);
        alu_valid = 1'b0;
        tests_run++;
        if (pending_mask[0] !== 1'b0 || pending_mask[9] !== 1'b1 || alu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reg0_mask: got mask=%h ar=%b expected bit0=0 bit9=1 ar=1", pending_mask, alu_ready);
        end
        drain();
    endtask

    task automatic test_starvation();
        logic        acc;
        logic [4:0]  exp_mem, exp_alu, exp_pos;
        logic [31:0] exp_val;
        exp_mem = 5'd1; exp_alu = 5'd16;
        mpos = 5'd1; mem_pos = 5'd1; mem_value = 32'h1000_0001; mem_valid = 1'b1;
        alu_valid = 1'b1; alu_pos = 5'd16; alu_value = 32'hA000_0010;
        cycle(acc);
        if (acc) begin alu_pos = alu_pos + 5'd1; alu_value = 32'hA000_0000 | 32'(alu_pos); end
        for (int j = 0; j < 16; j++) begin
            cycle(acc);
            if (acc) begin alu_pos = alu_pos + 5'd1; alu_value = 32'hA000_0000 | 32'(alu_pos); end
            if (j % 4 == 3) begin
                exp_pos = exp_alu; exp_val = 32'hA000_0000 | 32'(exp_alu); exp_alu = exp_alu + 5'd1;
            end else begin
                exp_pos = exp_mem; exp_val = 32'h1000_0000 | 32'(exp_mem); exp_mem = exp_mem + 5'd1;
            end
            tests_run++;
            if (wb_pos !== exp_pos || wb_value !== exp_val) begin
                tests_failed++;
                $display("[TB] FAIL starve_grant_%0d: got pos=%0d val=%h expected pos=%0d val=%h",
                         j, wb_pos, wb_value, exp_pos, exp_val);
            end
        end
        drain();
        tests_run++;
        if (pending_mask !== 32'd0 || wb_pos !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL starve_drain: got mask=%h pos=%0d expected 0 0", pending_mask, wb_pos);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [4:0] want [3];
        want[0] = 5'd20; want[1] = 5'd21; want[2] = 5'd22;
        alu_seen.delete();
        mpos = 5'd1; mem_pos = 5'd1; mem_value = 32'h1000_0001; mem_valid = 1'b1;
        alu_valid = 1'b1; alu_pos = 5'd20; alu_value = 32'hA000_0014;
        cycle(acc);
        alu_pos = 5'd21; alu_value = 32'hA000_0015;
        cycle(acc);
        alu_pos = 5'd22; alu_value = 32'hA000_0016;
        tests_run++;
        if (alu_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_full: got alu_ready=%b expected 0", alu_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(acc);
            tests_run++;
            if (acc !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold_%0d: got accepted=%b expected 0", k, acc);
            end
        end
        tests_run++;
        if (wb_pos !== 5'd20 || alu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_first_pop: got pos=%0d ar=%b expected 20 1", wb_pos, alu_ready);
        end
        cycle(acc);
        alu_valid = 1'b0;
        tests_run++;
        if (acc !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_third_accept: got accepted=%b expected 1", acc);
        end
        for (int n = 0; n < 20 && alu_seen.size() < 3; n++) cycle(acc);
        tests_run++;
        if (alu_seen.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: got %0d alu writebacks expected 3", alu_seen.size());
        end
        for (int i = 0; i < 3 && i < alu_seen.size(); i++) begin
            tests_run++;
            if (alu_seen[i] !== want[i]) begin
                tests_failed++;
                $display("[TB] FAIL bp_order_%0d: got pos=%0d expected %0d", i, alu_seen[i], want[i]);
            end
        end
        drain();
    endtask

    task automatic test_mid_reset();
        logic [31:0] r7, r8;
        r7 = rf[7];
        r8 = rf[8];
        mem_valid = 1'b1; mem_pos = 5'd7; mem_value = 32'h7777_7777;
        alu_valid = 1'b1; alu_pos = 5'd8; alu_value = 32'h8888_8888;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        tests_run++;
        if (pending_mask !== 32'h0000_0180 || wb_pos !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL mr_queued: got mask=%h pos=%0d expected 00000180 0", pending_mask, wb_pos);
        end
        tick();
        tests_run++;
        if (wb_pos !== 5'd7 || pending_mask !== 32'h0000_0100) begin
            tests_failed++;
            $display("[TB] FAIL mr_before: got pos=%0d mask=%h expected 7 00000100", wb_pos, pending_mask);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (wb_pos !== 5'd0 || wb_value !== 32'd0 || pending_mask !== 32'd0 ||
            alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mr_async: got pos=%0d val=%h mask=%h ar=%b mr=%b expected 0 0 0 0 0",
                     wb_pos, wb_value, pending_mask, alu_ready, mem_ready);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (wb_pos !== 5'd0 || pending_mask !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL mr_after_%0d: got pos=%0d mask=%h expected 0 0", i, wb_pos, pending_mask);
            end
        end
        tests_run++;
        if (rf[7] !== r7 || rf[8] !== r8) begin
            tests_failed++;
            $display("[TB] FAIL mr_no_write: got rf7=%h rf8=%h expected %h %h", rf[7], rf[8], r7, r8);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_reg0_drop();
        test_starvation();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
